// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and arbiter types for the two-master SRAM arbiter.
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_e;

  typedef struct packed {
    logic       hsel;
    logic [1:0] htrans;
    logic       hwrite;
    logic [2:0] hsize;
    logic [2:0] hburst;
    logic [3:0] hprot;
  } ahb_ctrl_t;
endpackage

// File: rtl/ahb_arb_in_stage.sv
// Per-master input stage: holds an address phase the arbiter could not issue
// and presents either the held phase or the live one.
module ahb_arb_in_stage
  import ahb_pkg::*;
#(
  parameter int ADDR_BITS = 12
) (
  input  logic                 hclk_i,
  input  logic                 hrst_i,
  input  logic [ADDR_BITS-1:0] haddr_i,
  input  ahb_ctrl_t            ctrl_i,
  input  logic                 hready_i,
  input  logic                 accept_i,
  output logic [ADDR_BITS-1:0] haddr_o,
  output ahb_ctrl_t            ctrl_o,
  output logic                 req_o,
  output logic                 pend_o
);
  logic                 live;
  logic [ADDR_BITS-1:0] addr_q;
  ahb_ctrl_t            ctrl_q;

  // A live phase only exists when the master itself sees hready high.
  assign live    = ctrl_i.hsel & ctrl_i.htrans[1] & hready_i;
  assign req_o   = live | pend_o;
  assign haddr_o = pend_o ? addr_q : haddr_i;
  assign ctrl_o  = pend_o ? ctrl_q : ctrl_i;

  always_ff @(posedge hclk_i or posedge hrst_i) begin
    if (hrst_i) begin
      pend_o <= 1'b0;
      addr_q <= '0;
      ctrl_q <= '0;
    end else if (pend_o && accept_i) begin
      pend_o <= 1'b0;
    end else if (live && !accept_i) begin
      pend_o <= 1'b1;
      addr_q <= haddr_i;
      ctrl_q <= ctrl_i;
    end
  end
endmodule

// File: rtl/ahb_sram_arbiter.sv
// Two-master AHB-Lite arbiter in front of the SRAM wrapper: burst-locked
// round-robin ownership with zero added latency when uncontended.
module ahb_sram_arbiter
  import ahb_pkg::*;
#(
  parameter int ADDR_BITS  = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  hclk_i,
  input  logic                  hrst_i,
  input  logic                  m0_hsel_i,
  input  logic [ADDR_BITS-1:0]  m0_haddr_i,
  input  logic [1:0]            m0_htrans_i,
  input  logic                  m0_hwrite_i,
  input  logic [2:0]            m0_hsize_i,
  input  logic [2:0]            m0_hburst_i,
  input  logic [3:0]            m0_hprot_i,
  input  logic [DATA_WIDTH-1:0] m0_hwdata_i,
  output logic                  m0_hreadyout_o,
  output logic [DATA_WIDTH-1:0] m0_hrdata_o,
  output logic                  m0_hresp_o,
  input  logic                  m1_hsel_i,
  input  logic [ADDR_BITS-1:0]  m1_haddr_i,
  input  logic [1:0]            m1_htrans_i,
  input  logic                  m1_hwrite_i,
  input  logic [2:0]            m1_hsize_i,
  input  logic [2:0]            m1_hburst_i,
  input  logic [3:0]            m1_hprot_i,
  input  logic [DATA_WIDTH-1:0] m1_hwdata_i,
  output logic                  m1_hreadyout_o,
  output logic [DATA_WIDTH-1:0] m1_hrdata_o,
  output logic                  m1_hresp_o,
  output logic                  s_hsel_o,
  output logic [ADDR_BITS-1:0]  s_haddr_o,
  output logic [1:0]            s_htrans_o,
  output logic                  s_hwrite_o,
  output logic [2:0]            s_hsize_o,
  output logic [2:0]            s_hburst_o,
  output logic [3:0]            s_hprot_o,
  output logic [DATA_WIDTH-1:0] s_hwdata_o,
  output logic                  s_hready_o,
  input  logic                  s_hreadyout_i,
  input  logic [DATA_WIDTH-1:0] s_hrdata_i,
  input  logic                  s_hresp_i
);
  arb_state_e                   st;
  logic                         last_grant, data_valid, data_owner;
  logic                         gnt_vld, gnt_id, own;
  ahb_ctrl_t [1:0]              ctrl_in, ctrl_sel;
  logic [1:0][ADDR_BITS-1:0]    addr_in, addr_sel;
  logic [1:0]                   req, pend, acc, hrdy, hresp;
  ahb_ctrl_t                    owner_ctrl;

  assign ctrl_in[0] = '{hsel: m0_hsel_i, htrans: m0_htrans_i, hwrite: m0_hwrite_i,
                        hsize: m0_hsize_i, hburst: m0_hburst_i, hprot: m0_hprot_i};
  assign ctrl_in[1] = '{hsel: m1_hsel_i, htrans: m1_htrans_i, hwrite: m1_hwrite_i,
                        hsize: m1_hsize_i, hburst: m1_hburst_i, hprot: m1_hprot_i};
  assign addr_in[0] = m0_haddr_i;
  assign addr_in[1] = m1_haddr_i;

  for (genvar n = 0; n < 2; n++) begin : g_in
    ahb_arb_in_stage #(.ADDR_BITS(ADDR_BITS)) u_in (
      .hclk_i   (hclk_i),
      .hrst_i   (hrst_i),
      .haddr_i  (addr_in[n]),
      .ctrl_i   (ctrl_in[n]),
      .hready_i (hrdy[n]),
      .accept_i (acc[n]),
      .haddr_o  (addr_sel[n]),
      .ctrl_o   (ctrl_sel[n]),
      .req_o    (req[n]),
      .pend_o   (pend[n])
    );
    assign acc[n]   = gnt_vld && (gnt_id == 1'(n)) && s_hreadyout_i;
    // A held phase keeps its master stalled even while a data phase completes.
    assign hrdy[n]  = pend[n] ? 1'b0 :
                      (data_valid && data_owner == 1'(n)) ? s_hreadyout_i : 1'b1;
    assign hresp[n] = (data_valid && data_owner == 1'(n)) ? s_hresp_i : HRESP_OKAY;
  end

  // Grant for the current address phase; held through SEQ/BUSY so bursts stay whole.
  assign own = (st == ARB_OWN1);
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (st != ARB_IDLE &&
        (ctrl_sel[own].htrans == HTRANS_SEQ || ctrl_sel[own].htrans == HTRANS_BUSY)) begin
      gnt_vld = 1'b1;
      gnt_id  = own;
    end else if (req[0] && req[1]) begin
      gnt_vld = 1'b1;
      gnt_id  = !last_grant;
    end else if (req[0] || req[1]) begin
      gnt_vld = 1'b1;
      gnt_id  = req[1];
    end
    if (hrst_i) gnt_vld = 1'b0;
  end

  assign owner_ctrl = ctrl_sel[gnt_id];
  assign s_hsel_o   = gnt_vld & owner_ctrl.hsel;
  assign s_htrans_o = gnt_vld ? owner_ctrl.htrans : HTRANS_IDLE;
  assign s_haddr_o  = addr_sel[gnt_id];
  assign s_hwrite_o = owner_ctrl.hwrite;
  assign s_hsize_o  = owner_ctrl.hsize;
  assign s_hburst_o = owner_ctrl.hburst;
  assign s_hprot_o  = owner_ctrl.hprot;
  assign s_hwdata_o = data_owner ? m1_hwdata_i : m0_hwdata_i;
  assign s_hready_o = s_hreadyout_i;

  assign m0_hreadyout_o = hrdy[0];
  assign m1_hreadyout_o = hrdy[1];
  assign m0_hresp_o     = hresp[0];
  assign m1_hresp_o     = hresp[1];
  assign m0_hrdata_o    = s_hrdata_i;
  assign m1_hrdata_o    = s_hrdata_i;

  always_ff @(posedge hclk_i or posedge hrst_i) begin
    if (hrst_i) begin
      st         <= ARB_IDLE;
      last_grant <= 1'b1;
      data_valid <= 1'b0;
      data_owner <= 1'b0;
    end else if (s_hreadyout_i) begin
      st         <= !gnt_vld ? ARB_IDLE : (gnt_id ? ARB_OWN1 : ARB_OWN0);
      if (gnt_vld && s_htrans_o == HTRANS_NONSEQ) last_grant <= gnt_id;
      data_valid <= s_hsel_o && s_htrans_o[1];
      data_owner <= gnt_id;
    end
  end
endmodule

// File: tb/tb_ahb_sram_arbiter.sv
// Directed bench for ahb_sram_arbiter with a zero/controlled-wait SRAM slave model.
module tb_ahb_sram_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        m0_hsel = 0, m1_hsel = 0, m0_hwrite = 0, m1_hwrite = 0;
  logic [11:0] m0_haddr = 0, m1_haddr = 0;
  logic [1:0]  m0_htrans = 0, m1_htrans = 0;
  logic [2:0]  m0_hburst = 0, m1_hburst = 0;
  logic [31:0] m0_hwdata = 0, m1_hwdata = 0;
  logic        m0_hreadyout, m1_hreadyout, m0_hresp, m1_hresp;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic        s_hsel, s_hwrite, s_hready, s_hresp;
  logic [11:0] s_haddr;
  logic [1:0]  s_htrans;
  logic [2:0]  s_hsize, s_hburst;
  logic [3:0]  s_hprot;
  logic [31:0] s_hwdata, s_hrdata;
  logic        stall = 0, err = 0;
  int          checks = 0, errors = 0;

  logic [31:0] mem [0:1023];
  logic        sl_dv, sl_wr;
  logic [11:0] sl_addr;

  always #5 clk = ~clk;

  ahb_sram_arbiter #(.ADDR_BITS(12), .DATA_WIDTH(32)) dut (
    .hclk_i(clk), .hrst_i(rst),
    .m0_hsel_i(m0_hsel), .m0_haddr_i(m0_haddr), .m0_htrans_i(m0_htrans), .m0_hwrite_i(m0_hwrite),
    .m0_hsize_i(3'd2), .m0_hburst_i(m0_hburst), .m0_hprot_i(4'd0), .m0_hwdata_i(m0_hwdata),
    .m0_hreadyout_o(m0_hreadyout), .m0_hrdata_o(m0_hrdata), .m0_hresp_o(m0_hresp),
    .m1_hsel_i(m1_hsel), .m1_haddr_i(m1_haddr), .m1_htrans_i(m1_htrans), .m1_hwrite_i(m1_hwrite),
    .m1_hsize_i(3'd2), .m1_hburst_i(m1_hburst), .m1_hprot_i(4'd0), .m1_hwdata_i(m1_hwdata),
    .m1_hreadyout_o(m1_hreadyout), .m1_hrdata_o(m1_hrdata), .m1_hresp_o(m1_hresp),
    .s_hsel_o(s_hsel), .s_haddr_o(s_haddr), .s_htrans_o(s_htrans), .s_hwrite_o(s_hwrite),
    .s_hsize_o(s_hsize), .s_hburst_o(s_hburst), .s_hprot_o(s_hprot), .s_hwdata_o(s_hwdata),
    .s_hready_o(s_hready), .s_hreadyout_i(!stall), .s_hrdata_i(s_hrdata), .s_hresp_i(s_hresp)
  );

  // SRAM slave: one-cycle data phase unless the bench stalls it
  assign s_hresp  = err;
  assign s_hrdata = (sl_dv && !sl_wr) ? mem[sl_addr[11:2]] : 32'h0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sl_dv <= 1'b0; sl_wr <= 1'b0; sl_addr <= '0;
    end else if (s_hready) begin
      if (sl_dv && sl_wr) mem[sl_addr[11:2]] <= s_hwdata;
      sl_dv   <= s_hsel & s_htrans[1];
      sl_wr   <= s_hwrite;
      sl_addr <= s_haddr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic sel, input logic [1:0] tr, input logic wr,
                      input logic [11:0] a, input logic [2:0] b);
    m0_hsel = sel; m0_htrans = tr; m0_hwrite = wr; m0_haddr = a; m0_hburst = b;
  endtask

  task automatic drv1(input logic sel, input logic [1:0] tr, input logic wr,
                      input logic [11:0] a, input logic [2:0] b);
    m1_hsel = sel; m1_htrans = tr; m1_hwrite = wr; m1_haddr = a; m1_hburst = b;
  endtask

  task automatic nxt;
    @(posedge clk); #1;
  endtask

  task automatic mid;
    #3;
  endtask

  initial begin
    // reset values
    nxt; nxt; mid;
    chk("rst_htrans", 32'(s_htrans), 32'd0);
    chk("rst_hsel", 32'(s_hsel), 32'd0);
    chk("rst_m0_rdy", 32'(m0_hreadyout), 32'd1);
    chk("rst_m1_rdy", 32'(m1_hreadyout), 32'd1);
    chk("rst_m0_resp", 32'(m0_hresp), 32'd0);

    // single master write then read, no stalls
    nxt; rst = 0;
    drv0(1, 2'b10, 1, 12'h010, 3'd0); mid;
    chk("sm_wr_addr", 32'(s_haddr), 32'h010);
    chk("sm_wr_trans", 32'(s_htrans), 32'd2);
    chk("sm_wr_rdy", 32'(m0_hreadyout), 32'd1);
    nxt; drv0(1, 2'b10, 0, 12'h010, 3'd0); m0_hwdata = 32'hA5A5A5A5; mid;
    chk("sm_rd_rdy", 32'(m0_hreadyout), 32'd1);
    chk("sm_hwdata", s_hwdata, 32'hA5A5A5A5);
    chk("sm_rd_addr", 32'(s_haddr), 32'h010);
    nxt; drv0(0, 2'b00, 0, 12'h000, 3'd0); mid;
    chk("sm_rdata", m0_hrdata, 32'hA5A5A5A5);
    chk("sm_rdata_bcast", m1_hrdata, 32'hA5A5A5A5);

    // collision from reset: M0 wins, M1 pends one cycle
    nxt; rst = 1; nxt; rst = 0;
    drv0(1, 2'b10, 0, 12'h020, 3'd0); drv1(1, 2'b10, 0, 12'h040, 3'd0); mid;
    chk("col_addr0", 32'(s_haddr), 32'h020);
    chk("col_m1_rdy0", 32'(m1_hreadyout), 32'd1);
    nxt; drv0(0, 2'b00, 0, 0, 0); drv1(0, 2'b00, 0, 0, 0); mid;
    chk("col_m1_rdy1", 32'(m1_hreadyout), 32'd0);
    chk("col_addr1", 32'(s_haddr), 32'h040);
    chk("col_trans1", 32'(s_htrans), 32'd2);
    nxt; mid;
    chk("col_m1_rdy2", 32'(m1_hreadyout), 32'd1);
    chk("col_idle", 32'(s_htrans), 32'd0);

    // burst lock: M0 INCR4, M1 arrives at beat 2
    nxt; drv0(1, 2'b10, 1, 12'h100, 3'b011); mid;
    chk("bl_b1", 32'(s_haddr), 32'h100);
    nxt; drv0(1, 2'b11, 1, 12'h104, 3'b011); drv1(1, 2'b10, 1, 12'h200, 3'd0); mid;
    chk("bl_b2", 32'(s_haddr), 32'h104);
    chk("bl_b2_trans", 32'(s_htrans), 32'd3);
    nxt; drv0(1, 2'b11, 1, 12'h108, 3'b011); mid;
    chk("bl_b3", 32'(s_haddr), 32'h108);
    chk("bl_m1_pend", 32'(m1_hreadyout), 32'd0);
    nxt; drv0(1, 2'b11, 1, 12'h10C, 3'b011); mid;
    chk("bl_b4", 32'(s_haddr), 32'h10C);
    nxt; drv0(0, 2'b00, 0, 0, 0); mid;
    chk("bl_m1_addr", 32'(s_haddr), 32'h200);
    chk("bl_m1_trans", 32'(s_htrans), 32'd2);
    nxt; drv1(0, 2'b00, 0, 0, 0); mid;
    chk("bl_m1_done", 32'(m1_hreadyout), 32'd1);

    // round-robin with both masters streaming single reads
    nxt; drv0(1, 2'b10, 0, 12'h300, 3'd0); drv1(1, 2'b10, 0, 12'h304, 3'd0); mid;
    chk("rr_0", 32'(s_haddr), 32'h300);
    nxt; mid; chk("rr_1", 32'(s_haddr), 32'h304);
    nxt; mid; chk("rr_2", 32'(s_haddr), 32'h300);
    nxt; mid; chk("rr_3", 32'(s_haddr), 32'h304);
    nxt; drv0(0, 2'b00, 0, 0, 0); drv1(0, 2'b00, 0, 0, 0); mid;
    chk("rr_4_pended", 32'(s_haddr), 32'h300);
    chk("rr_4_trans", 32'(s_htrans), 32'd2);
    nxt; mid; chk("rr_5_idle", 32'(s_htrans), 32'd0);

    // wait states in an M1 data phase; M0 request must survive
    nxt; drv1(1, 2'b10, 0, 12'h044, 3'd0); mid;
    chk("ws_m1_addr", 32'(s_haddr), 32'h044);
    nxt; drv1(0, 2'b00, 0, 0, 0); drv0(1, 2'b10, 1, 12'h050, 3'd0); stall = 1; mid;
    chk("ws_m1_stall1", 32'(m1_hreadyout), 32'd0);
    chk("ws_m0_rdy1", 32'(m0_hreadyout), 32'd1);
    nxt; mid;
    chk("ws_m1_stall2", 32'(m1_hreadyout), 32'd0);
    chk("ws_m0_pend", 32'(m0_hreadyout), 32'd0);
    nxt; stall = 0; mid;
    chk("ws_m1_done", 32'(m1_hreadyout), 32'd1);
    chk("ws_m0_addr", 32'(s_haddr), 32'h050);
    chk("ws_m0_trans", 32'(s_htrans), 32'd2);
    nxt; drv0(0, 2'b00, 0, 0, 0); mid;
    chk("ws_m0_done", 32'(m0_hreadyout), 32'd1);

    // two-cycle ERROR response reaches the owner only
    nxt; drv0(1, 2'b10, 0, 12'h060, 3'd0); mid;
    nxt; drv0(0, 2'b00, 0, 0, 0); stall = 1; err = 1; mid;
    chk("er_resp1", 32'(m0_hresp), 32'd1);
    chk("er_rdy1", 32'(m0_hreadyout), 32'd0);
    nxt; stall = 0; mid;
    chk("er_resp2", 32'(m0_hresp), 32'd1);
    chk("er_rdy2", 32'(m0_hreadyout), 32'd1);
    chk("er_m1_resp", 32'(m1_hresp), 32'd0);
    nxt; err = 0; mid;
    chk("er_idle", 32'(s_htrans), 32'd0);

    // reset during M1 INCR beat 3 with an M0 phase pending
    nxt; drv1(1, 2'b10, 0, 12'h400, 3'b001); mid;
    chk("rm_b1", 32'(s_haddr), 32'h400);
    nxt; drv1(1, 2'b11, 0, 12'h404, 3'b001); drv0(1, 2'b10, 1, 12'h080, 3'd0); mid;
    chk("rm_b2", 32'(s_haddr), 32'h404);
    nxt; drv1(1, 2'b11, 0, 12'h408, 3'b001); mid;
    chk("rm_b3_trans", 32'(s_htrans), 32'd3);
    chk("rm_m0_pend", 32'(m0_hreadyout), 32'd0);
    rst = 1; #1;
    chk("rm_htrans", 32'(s_htrans), 32'd0);
    chk("rm_hsel", 32'(s_hsel), 32'd0);
    chk("rm_m0_rdy", 32'(m0_hreadyout), 32'd1);
    chk("rm_m1_rdy", 32'(m1_hreadyout), 32'd1);
    drv0(0, 2'b00, 0, 0, 0); drv1(0, 2'b00, 0, 0, 0);
    nxt; rst = 0; nxt; mid;
    chk("rm_after", 32'(s_htrans), 32'd0);
    chk("rm_after_rdy", 32'(m0_hreadyout), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
